// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and clear-mask helper for the interrupt pending controller.
package irq_pkg;

    localparam int N_IRQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    function automatic logic [N_IRQ-1:0] onehot_of_id(input logic [ID_W-1:0] id);
        logic [N_IRQ-1:0] m;
        m     = '0;
        m[id] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational highest-set-bit selector: bit N_IRQ-1 has top priority.
module irq_prio_sel
    import irq_pkg::*;
(
    input  logic [N_IRQ-1:0] vec_i,
    output logic [ID_W-1:0]  id_o,
    output logic             nz_o
);

    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        id_o = '0;
        nz_o = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (vec_i[i]) begin
                id_o = ID_W'(i);
                nz_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/mask front end with a valid/ack ID handshake.
// Define IRQ_LEVEL_MODE_EN for level-sensitive capture (default: rising-edge capture).
module irq_pending_ctrl
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] req,
    input  logic [N_IRQ-1:0] mask,
    input  logic             ack,
    input  logic             ovf_clr,
    output logic             vld,
    output logic [ID_W-1:0]  id,
    output logic [N_IRQ-1:0] pend_o,
    output logic             any_pend,
    output logic             ovf
);

    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] req_q;
    logic [N_IRQ-1:0] ev;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] pend_masked;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  sel_id;
    logic             sel_nz;
    logic             ovf_q, ovf_d;
    state_e           state_q, state_d;

`ifdef IRQ_LEVEL_MODE_EN
    assign ev = req;
`else
    assign ev = req & ~req_q;
`endif

    assign pend_masked = pending_q & ~mask;
    assign pend_o      = pend_masked;
    assign any_pend    = |pend_masked;
    assign vld         = (state_q == PRESENT);
    assign id          = id_q;
    assign ovf         = ovf_q;

    // Only an ack against a presented ID clears anything.
    assign clr       = (ack && vld) ? onehot_of_id(id_q) : '0;
    assign pending_d = (pending_q & ~clr) | ev;

`ifdef IRQ_LEVEL_MODE_EN
    assign ovf_d = ovf_q & ~ovf_clr;
`else
    assign ovf_d = (|(ev & pending_q & ~clr)) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
`endif

    irq_prio_sel u_prio_sel (
        .vec_i (pend_masked),
        .id_o  (sel_id),
        .nz_o  (sel_nz)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (sel_nz) begin
                    id_d    = sel_id;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            req_q     <= '0;
            ovf_q     <= 1'b0;
            id_q      <= '0;
            state_q   <= IDLE;
        end else begin
            pending_q <= pending_d;
            req_q     <= req;
            ovf_q     <= ovf_d;
            id_q      <= id_d;
            state_q   <= state_d;
        end
    end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Front-end interrupt controller for the 8-line priority encoding path.
- Captures request events on 8 lines into a pending register and applies a mask.
- Selects the highest-priority unmasked pending line (line 7 highest) and presents its 3-bit ID to a consumer over a valid/ack handshake.
- Clears the served pending bit on acknowledge. Exports the masked pending vector so a downstream 8-to-3 encoder stage can observe it.

Parameters:
- N_IRQ, 8, number of request lines. Only 8 is supported.
- ID_W, 3, width of the ID; equals log2(N_IRQ).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request lines, synchronous to clk.
- mask  input  8  1 = line masked. Masked lines still pend but are not presented.
- ack  input  1  consumer accepts the presented ID; effective only when vld=1.
- ovf_clr  input  1  clears the ovf sticky flag.
- vld  output  1  id is valid and held.
- id  output  3  highest-priority pending unmasked line.
- pend_o  output  8  pending & ~mask; feeds the downstream encoder stage.
- any_pend  output  1  OR-reduction of pend_o.
- ovf  output  1  sticky flag: an event arrived on a line whose pending bit was already set.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pending, req_q and ovf are cleared to 0; vld=0; id=3'b000; state=IDLE.
  - rst has priority over every other input.
  - Reset mid-PRESENT drops the outstanding ID without a clear cycle.
- Event detect: ev = req & ~req_q, where req_q is req registered every cycle.
  - req_q resets to 0, so a line held high through reset yields one event on the first post-reset edge.
- Pending update each cycle: pending <= (pending & ~clr) | ev.
  - clr is the one-hot of id when ack & vld, else 0.
  - Set wins: an event on the bit being cleared in the same cycle leaves it pending.
- ovf is set when ev[i] & pending[i] & ~clr[i] for any i. It holds until ovf_clr or rst. If set and clear occur in the same cycle, set wins.
- FSM, 2 states:
  - IDLE: vld=0. If any_pend, latch id = index of highest set bit of pend_o, set vld=1, go to PRESENT.
  - PRESENT: vld=1 and id held stable regardless of mask/req changes (no retraction). On ack, clear pending[id], drive vld=0, go to IDLE.
- Latency:
  - req rises before edge k → pending set after edge k → vld=1 with id after edge k+1.
  - After ack at edge m, vld=0 for at least one cycle. The next ID is presented after edge m+1 at the earliest.
- ack while vld=0 is ignored (no state change, no clear).
- Unmasking a pending line makes it eligible at the next IDLE evaluation. Masking never clears a pending bit.
- pend_o and any_pend are combinational from registered pending and the mask input.

Optional Feature:
- Macro IRQ_LEVEL_MODE_EN.
- Defined: ev = req (level mode). Pending re-sets every cycle while the line is high. ovf is not updated and stays 0. A line held high re-presents after each ack.
- Undefined (default): rising-edge capture as described in Behaviour.

Decomposition:
- Package irq_pkg holds N_IRQ, ID_W, the FSM state enum (IDLE, PRESENT), and a function onehot_of_id(id) returning the 8-bit clear mask.
- One sub-module, irq_prio_sel: combinational 8→3 highest-set-bit selector with a nonzero flag. It is instantiated once to compute the next id.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req=0 → vld=0, id=0, pend_o=0, ovf=0; holds with no stimulus.
- Single event: req[5] pulses at edge 10, mask=0 → pend_o=8'h20 after edge 10; vld=1, id=5 after edge 11. Ack at edge 13 → vld=0, pend_o=0 after edge 13.
- Priority and order: req[1] and req[6] rise together → id=6 first; after ack, one vld-low cycle, then id=1; after second ack, any_pend=0.
- Mask: mask=8'h80, event on 7 and 2 → id=2, pend_o=8'h04. Clear mask while PRESENT → id stays 2. After ack → id=7.
- Overflow and set-wins: second rising edge on req[3] while pending[3]=1 → ovf=1. Event on req[3] in the same cycle as its ack → pending[3] stays 1, id=3 re-presented. ovf_clr → ovf=0.
- Reset mid-operation: rst asserted while vld=1, id=4 → after that edge vld=0, pending=0. ack in the reset cycle has no effect.
